// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial N-bit add/subtract unit (LSB first, one bit per clock)
//            built around a 1-bit full add/subtract cell and a carry/borrow flop.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb_out,
  output logic             ser_bit,
  output logic             ser_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last_count = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_op;
  logic             r_cb;

  logic w_x;
  logic w_y;
  logic w_bit;
  logic w_cb_next;

  // 1-bit full add/subtract cell; the same sum/difference bit serves both ops
  always_comb begin
    w_x   = r_a_sh[0];
    w_y   = r_b_sh[0];
    w_bit = w_x ^ w_y ^ r_cb;
    if (r_op) begin
      w_cb_next = (~w_x & w_y) | (r_cb & ~(w_x ^ w_y));
    end else begin
      w_cb_next = (w_x & w_y) | (r_cb & (w_x ^ w_y));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_cb     <= 1'b0;
      r_op     <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_op    <= op;
            r_cb    <= 1'b0;
            r_count <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // New bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts
          r_result <= {w_bit, r_result[WIDTH-1:1]};
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cb     <= w_cb_next;
          r_count  <= r_count + CW'(1);
          if (r_count == c_last_count) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign ser_valid = (r_state == S_SHIFT);
  // The cell output is only meaningful while shifting; the leftover flop value in IDLE must not leak
  assign ser_bit   = ser_valid & w_bit;
  assign result    = r_result;
  assign cb_out    = r_cb;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam logic [31:0] c_mask = (32'd1 << WIDTH) - 32'd1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cb_out;
  logic             ser_bit;
  logic             ser_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  serial_subtractor #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cb_out    (cb_out),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on the operand values
  function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mop);
    logic [31:0] res;
    logic        cb;
    if (mop) begin
      res = (ma - mb) & c_mask;
      cb  = (ma < mb);
    end else begin
      res = (ma + mb) & c_mask;
      cb  = ((ma + mb) >> WIDTH) != 0;
    end
    return {cb, res};
  endfunction

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"},   32'(busy),      32'd0);
    check_eq({tag, "_done"},   32'(done),      32'd0);
    check_eq({tag, "_result"}, 32'(result),    32'd0);
    check_eq({tag, "_cb"},     32'(cb_out),    32'd0);
    check_eq({tag, "_sbit"},   32'(ser_bit),   32'd0);
    check_eq({tag, "_sval"},   32'(ser_valid), 32'd0);
  endtask

  // One full operation; optionally scramble the operand inputs after acceptance
  task automatic do_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vop, input bit scramble);
    logic [32:0] exp;
    exp = model(32'(va), 32'(vb), vop);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; op = vop;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      op = ~vop;
    end
    for (int i = 0; i < WIDTH; i++) begin
      check_eq({tag, "_sval"}, 32'(ser_valid), 32'd1);
      check_eq({tag, "_sbit"}, 32'(ser_bit),   32'((exp[31:0] >> i) & 32'd1));
      check_eq({tag, "_busy"}, 32'(busy),      32'd1);
      check_eq({tag, "_done_early"}, 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    // WIDTH edges after the accepting edge: the DONE cycle
    check_eq({tag, "_done"},   32'(done),      32'd1);
    check_eq({tag, "_busyd"},  32'(busy),      32'd1);
    check_eq({tag, "_svald"},  32'(ser_valid), 32'd0);
    check_eq({tag, "_result"}, 32'(result),    exp[31:0]);
    check_eq({tag, "_cb"},     32'(cb_out),    32'(exp[32]));
    @(posedge clk); #1;
    check_eq({tag, "_done_off"}, 32'(done),   32'd0);
    check_eq({tag, "_idle"},     32'(busy),   32'd0);
    check_eq({tag, "_hold_res"}, 32'(result), exp[31:0]);
    check_eq({tag, "_hold_cb"},  32'(cb_out), 32'(exp[32]));
  endtask

  initial begin
    int n_done;
    int last_done;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op("sub_5a_3c", 8'h5A, 8'h3C, 1'b1, 1'b0);
    do_op("sub_wrap",  8'h00, 8'h01, 1'b1, 1'b0);
    do_op("sub_equal", 8'h80, 8'h80, 1'b1, 1'b0);
    do_op("add_ovf",   8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("add_plain", 8'h12, 8'h34, 1'b0, 1'b1);

    // start held high: accepted every WIDTH+2 edges, ignored while busy
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h01; op = 1'b1;
    @(posedge clk); #1;
    n_done = 0;
    last_done = 0;
    for (int e = 1; e < 30; e++) begin
      @(posedge clk); #1;
      check_eq("busy_rej_done", 32'(done), 32'((e % (WIDTH + 2)) == WIDTH));
      if (done) begin
        n_done++;
        check_eq("busy_rej_result", 32'(result), 32'h0F);
        if (n_done > 1) check_eq("busy_rej_interval", 32'(e - last_done), 32'(WIDTH + 2));
        last_done = e;
      end
      if (e == 22) begin
        a = '0;
        b = '0;
      end
      if (e == 29) start = 1'b0;
    end
    check_eq("busy_rej_count", 32'(n_done), 32'd3);

    // Reset during the 4th SHIFT cycle
    @(negedge clk);
    start = 1'b1; a = 8'h77; b = 8'h11; op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_busy_pre", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("mid_rst");
    do_op("post_rst_sub", 8'h03, 8'h01, 1'b1, 1'b0);

    // Idle after reset with no start
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_idle_zero("idle");
    end

    // Randomized operations, scrambling inputs after acceptance on half of them
    for (int n = 0; n < 40; n++) begin
      do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit add/subtract unit built around a 1-bit full add/subtract cell and a carry/borrow flip-flop.
- Primary function is subtraction (difference and borrow), the inverse operation of the combinational full-adder datapath. Also runs addition when `op`=0.
- Operands are loaded in parallel, processed LSB-first at one bit per clock, and returned in parallel and serially.
- Sits behind the top-level pin wrapper: operands come from dedicated inputs, results go to dedicated outputs.

Parameters:
WIDTH  8  operand/result width in bits (legal 2..16)

Ports:
clk         input   1      system clock; all state updates on rising edge
rst         input   1      reset: synchronous, active-high
start       input   1      request; sampled only in IDLE
op          input   1      0 = add (a+b), 1 = subtract (a-b); latched on accepted start
a           input   WIDTH  operand A; latched on accepted start
b           input   WIDTH  operand B; latched on accepted start
busy        output  1      high in SHIFT and DONE
done        output  1      one-cycle pulse: result valid
result      output  WIDTH  parallel sum/difference
cb_out      output  1      final carry (add) or borrow (sub)
ser_bit     output  1      current serial result bit, LSB first
ser_valid   output  1      high when ser_bit is valid (SHIFT only)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- rst=1 at a clock edge forces the following, overriding everything else including mid-operation:
  - state=IDLE, count=0, carry/borrow flop=0;
  - result=0, cb_out=0, busy=0, done=0, ser_bit=0, ser_valid=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches a, b, op into shift registers.
  - Carry/borrow flop is cleared to 0; count is cleared to 0.
  - Next state is SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one bit per cycle. With x=a_sh[0], y=b_sh[0], c=flop:
  - bit = x^y^c.
  - Add: c' = (x&y)|(c&(x^y)).
  - Sub: c' = (~x&y)|(c&~(x^y)).
  - bit shifts into result from the MSB end; a_sh and b_sh shift right.
  - ser_bit = bit (combinational from current regs), ser_valid=1.
  - count increments; at the edge where count==WIDTH-1 the last bit is processed and next state is DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - result holds the full WIDTH-bit answer; cb_out = final flop value.
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge E0 → SHIFT occupies cycles E0+1..E0+WIDTH → done high in cycle E0+WIDTH+1. Issue interval is WIDTH+2 cycles.
- start in SHIFT or DONE is ignored; it is not queued.
- result and cb_out hold their last values in IDLE until the next accepted start.
- Arithmetic width: result is modulo 2^WIDTH.
  - Sub with a<b gives the two's-complement wrap and cb_out=1.
  - Add overflow sets cb_out=1.
- Operand inputs may change freely after the accepting edge without affecting the operation.

Test Plan:
- Sub: WIDTH=8, op=1, a=0x5A, b=0x3C, start pulse → done exactly 9 cycles after the start edge; result=0x1E, cb_out=0; ser_bit sequence LSB-first 0,1,1,1,1,0,0,0.
- Sub wrap: op=1, a=0x00, b=0x01 → result=0xFF, cb_out=1; a=0x80, b=0x80 → result=0x00, cb_out=0.
- Add: op=0, a=0xFF, b=0x01 → result=0x00, cb_out=1; a=0x12, b=0x34 → result=0x46, cb_out=0.
- Busy rejection: start held high continuously with a=0x10, b=0x01, op=1 → one done per 10 cycles (result=0x0F each time). Additionally, changing a and b to 0x00/0x00 during SHIFT leaves the current result at 0x0F.
- Reset mid-op: rst=1 at the 4th SHIFT cycle → next cycle busy=0, done=0, result=0x00, cb_out=0, ser_valid=0. Then a new start with a=0x03, b=0x01, op=1 → result=0x02.
- Post-reset idle: after rst, 20 cycles with start=0 → done never asserts, busy=0, all outputs 0.
